output_credit_control: RTL and testbench
========================================

// Module: output_credit_control
// PURPOSE
//  Per-output-port credit tracker that generates the downstream-availability enables (i_en) consumed by the
//  router switch allocator. One credit = one free flit slot in the downstream input FIFO. Credits are spent
//  when the allocator grants an output and returned by the downstream router. A per-port FSM blocks
//  exhausted ports and fences off ports whose credit accounting has become inconsistent.
// PARAMETERS
//  M           `M   number of output ports
//  N           `N   number of local inputs (width of each grant row)
//  DEPTH       4    downstream FIFO depth = initial credits per port (>=1)
//  WDOG_LIMIT  16   consecutive BLOCKED cycles before watchdog flag (used only with CREDIT_WATCHDOG_EN)
// PORTS
//  clk             in   1        clock
//  reset_n         in   1        synchronous, active-low reset
//  ce              in   1        clock enable; when 0, all state holds
//  i_output_grant  in   [M][N]   allocator grants, row m one-hot or zero; any nonzero row = one flit sent on m
//  i_credit_ret    in   [M]      downstream returns one credit for port m this cycle
//  i_clear         in   [M]      per-port recovery pulse: exits ERROR, clears sticky flags
//  o_en            out  [M]      port m may be requested (feeds allocator i_en)
//  o_credit        out  [M][CW]  current credit count, CW = $clog2(DEPTH+1)
//  o_err           out  [M]      sticky credit underflow/overflow flag
//  o_wdog          out  [M]      sticky starvation flag (tied 0 without CREDIT_WATCHDOG_EN)
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge, regardless of ce): credit=DEPTH, state=READY, o_en=1, o_err=0, o_wdog=0.
//  - Updates only when ce=1. sent=|grant[m]; credit_next = credit - sent + ret, computed CW+1 bits wide.
//  - Latency: grant/return in cycle t visible on o_credit/o_en in cycle t+1; o_en decoded from registers only.
//  - FSM per port:
//    READY:   credit>0, o_en=1. -> BLOCKED when credit_next==0; -> ERROR on overflow.
//    BLOCKED: credit==0, o_en=0. -> READY on ret without sent; -> ERROR if sent (underflow).
//    ERROR:   o_en=0, credit frozen, inputs ignored. -> READY on i_clear (credit reloaded to DEPTH).
//  - Underflow: sent while credit==0. Overflow: ret && !sent while credit==DEPTH. Either sets o_err next cycle.
//  - Simultaneous sent+ret: net zero, state unchanged, including at credit==0 (no underflow) and credit==DEPTH.
//  - i_clear in READY/BLOCKED: clears o_err/o_wdog only; credit untouched. i_clear beats sent/ret same cycle.
//  - Ports fully independent; no cross-port interaction.
//  - Reset mid-operation discards all in-flight accounting; downstream must be reset together.
// CONFIGURATION
//  CREDIT_WATCHDOG_EN defined: per-port counter counts consecutive ce=1 cycles in BLOCKED, saturating;
//    reaching WDOG_LIMIT sets o_wdog[m] (sticky, cleared only by i_clear or reset); counter zeroes on
//    leaving BLOCKED. Not defined: counters absent, o_wdog driven '0.
// STRUCTURE
//  - Package router_credit_pkg: enum credit_state_e {CS_READY, CS_BLOCKED, CS_ERROR}, CW width function.
//  - Sub-module credit_port_ctrl: one port (counter, FSM, flags, optional watchdog); top generates M instances
//    and reduces each grant row to a single sent bit.
// TESTING (DEPTH=4, WDOG_LIMIT=8)
//  1. Release reset -> all o_credit=4, o_en='1, o_err=0, o_wdog=0.
//  2. Grant port 0 four consecutive cycles, no returns -> o_credit[0] 3,2,1,0; o_en[0]=0 after 4th; others 1.
//  3. At credit 1, sent+ret same cycle -> credit stays 1, o_en stays 1; at credit 0, both -> stays 0, no err.
//  4. Grant port 1 while credit 0 -> o_err[1]=1 next cycle, o_en[1]=0, returns ignored; i_clear -> credit 4, READY.
//  5. ce=0 for 5 cycles with grants and returns toggling -> no change in any output.
//  6. Hold port 2 BLOCKED 8 cycles -> o_wdog[2]=1; credit return keeps it 1; i_clear drops it.

Source files
------------

// File: rtl/router_credit_pkg.sv
// rtl/router_credit_pkg.sv - shared state encoding and credit-width helper for output credit control
package router_credit_pkg;

  typedef enum logic [1:0] {
    CS_READY,
    CS_BLOCKED,
    CS_ERROR
  } credit_state_e;

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/credit_port_ctrl.sv
// rtl/credit_port_ctrl.sv - single-port credit counter, READY/BLOCKED/ERROR fsm and sticky flags
// Optional starvation watchdog under CREDIT_WATCHDOG_EN.
module credit_port_ctrl
  import router_credit_pkg::*;
#(
  parameter int DEPTH = 4,
`ifdef CREDIT_WATCHDOG_EN
  parameter int WDOG_LIMIT = 16,
`endif
  localparam int CW = credit_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          sent,
  input  logic          ret,
  input  logic          clear,
  output logic          en,
  output logic [CW-1:0] credit,
  output logic          err,
  output logic          wdog
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  credit_state_e state;
  logic [CW:0]   nxt;
  logic          underflow;
  logic          overflow;

  // One extra bit so a would-be wrap is distinguishable from a legal zero.
  always_comb begin
    nxt = {1'b0, credit} - {{CW{1'b0}}, sent} + {{CW{1'b0}}, ret};
  end

  assign underflow = sent && !ret && (credit == '0);
  assign overflow  = ret && !sent && (credit == FULL);
  assign en        = (state == CS_READY);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= CS_READY;
      credit <= FULL;
      err    <= 1'b0;
    end else if (ce) begin
      if (state == CS_ERROR) begin
        if (clear) begin
          state  <= CS_READY;
          credit <= FULL;
          err    <= 1'b0;
        end
      end else if (clear) begin
        err <= 1'b0;
      end else if (underflow || overflow) begin
        state <= CS_ERROR;
        err   <= 1'b1;
      end else begin
        credit <= nxt[CW-1:0];
        state  <= (nxt == '0) ? CS_BLOCKED : CS_READY;
      end
    end
  end

`ifdef CREDIT_WATCHDOG_EN
  localparam int            WW   = $clog2(WDOG_LIMIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(WDOG_LIMIT);

  logic [WW-1:0] wcnt;

  // Saturating counter fires the flag once per blocked episode.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wcnt <= '0;
      wdog <= 1'b0;
    end else if (ce) begin
      if (state != CS_BLOCKED) begin
        wcnt <= '0;
      end else if (wcnt != WMAX) begin
        wcnt <= wcnt + WW'(1);
      end
      if (clear) begin
        wdog <= 1'b0;
      end else if (state == CS_BLOCKED && wcnt == WMAX - WW'(1)) begin
        wdog <= 1'b1;
      end
    end
  end
`else
  assign wdog = 1'b0;
`endif

endmodule

// File: rtl/output_credit_control.sv
// rtl/output_credit_control.sv - per-output-port credit tracker producing allocator enables
// Optional starvation watchdog under CREDIT_WATCHDOG_EN.
module output_credit_control
  import router_credit_pkg::*;
#(
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int DEPTH = 4,
`ifdef CREDIT_WATCHDOG_EN
  parameter int WDOG_LIMIT = 16,
`endif
  localparam int CW = credit_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic [M-1:0][N-1:0]   i_output_grant,
  input  logic [M-1:0]          i_credit_ret,
  input  logic [M-1:0]          i_clear,
  output logic [M-1:0]          o_en,
  output logic [M-1:0][CW-1:0]  o_credit,
  output logic [M-1:0]          o_err,
  output logic [M-1:0]          o_wdog
);

  for (genvar g = 0; g < M; g++) begin : g_port
    credit_port_ctrl #(
      .DEPTH(DEPTH)
`ifdef CREDIT_WATCHDOG_EN
      , .WDOG_LIMIT(WDOG_LIMIT)
`endif
    ) u_port (
      .clk    (clk),
      .reset_n(reset_n),
      .ce     (ce),
      .sent   (|i_output_grant[g]),
      .ret    (i_credit_ret[g]),
      .clear  (i_clear[g]),
      .en     (o_en[g]),
      .credit (o_credit[g]),
      .err    (o_err[g]),
      .wdog   (o_wdog[g])
    );
  end

endmodule

// File: tb/tb_output_credit_control.sv
// tb/tb_output_credit_control.sv - randomized self-checking bench for output_credit_control
module tb_output_credit_control;

  localparam int M          = 4;
  localparam int N          = 4;
  localparam int DEPTH      = 4;
  localparam int WDOG_LIMIT = 8;
  localparam int CW         = 3;
`ifdef CREDIT_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 ce;
  logic [M-1:0][N-1:0]  grant;
  logic [M-1:0]         ret;
  logic [M-1:0]         clr;
  logic [M-1:0]         o_en;
  logic [M-1:0][CW-1:0] o_credit;
  logic [M-1:0]         o_err;
  logic [M-1:0]         o_wdog;

  // Reference model: credits as integers, error mode and blocked-run length per port.
  int mc[M];
  bit mx[M];
  bit me[M];
  bit mw[M];
  int mb[M];

  logic [M-1:0]         e_en;
  logic [M-1:0]         e_err;
  logic [M-1:0]         e_wdog;
  logic [M-1:0][CW-1:0] e_credit;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  output_credit_control #(
    .M(M),
    .N(N),
    .DEPTH(DEPTH)
`ifdef CREDIT_WATCHDOG_EN
    , .WDOG_LIMIT(WDOG_LIMIT)
`endif
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ce            (ce),
    .i_output_grant(grant),
    .i_credit_ret  (ret),
    .i_clear       (clr),
    .o_en          (o_en),
    .o_credit      (o_credit),
    .o_err         (o_err),
    .o_wdog        (o_wdog)
  );

  task automatic model_update();
    for (int m = 0; m < M; m++) begin
      int s;
      int r;
      int net;
      bit c;
      bit blk;
      s = (grant[m] != '0) ? 1 : 0;
      r = ret[m] ? 1 : 0;
      c = clr[m];
      if (!reset_n) begin
        mc[m] = DEPTH; mx[m] = 0; me[m] = 0; mw[m] = 0; mb[m] = 0;
      end else if (ce) begin
        blk   = !mx[m] && (mc[m] == 0);
        mb[m] = blk ? mb[m] + 1 : 0;
        if (WD_ON && blk && mb[m] == WDOG_LIMIT && !c) mw[m] = 1;
        if (mx[m]) begin
          if (c) begin
            mx[m] = 0; mc[m] = DEPTH; me[m] = 0; mw[m] = 0;
          end
        end else if (c) begin
          me[m] = 0; mw[m] = 0;
        end else begin
          net = mc[m] - s + r;
          if (net < 0 || net > DEPTH) begin
            mx[m] = 1; me[m] = 1;
          end else begin
            mc[m] = net;
          end
        end
      end
      e_en[m]     = !mx[m] && (mc[m] > 0);
      e_credit[m] = CW'(mc[m]);
      e_err[m]    = me[m];
      e_wdog[m]   = mw[m];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    grant = '0;
    ret   = '0;
    clr   = '0;
    ce    = 1'b1;
  endtask

  task automatic send_on(input int p);
    grant[p] = '0;
    grant[p][$urandom_range(N-1, 0)] = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    ce      = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    ce      = 1'b1;
    for (int m = 0; m < M; m++) begin
      checks++;
      if (o_credit[m] !== 3'd4 || o_en[m] !== 1'b1 || o_err[m] !== 1'b0 || o_wdog[m] !== 1'b0) begin
        errors++;
        $display("FAIL reset port%0d: credit=%0d en=%b err=%b wdog=%b required credit=4 en=1 err=0 wdog=0",
                 m, o_credit[m], o_en[m], o_err[m], o_wdog[m]);
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      idle();
      send_on(0);
      step();
      checks++;
      if (o_credit[0] !== CW'(3 - i) || o_credit !== e_credit) begin
        errors++;
        $display("FAIL drain step%0d: credit=%h required=%h", i, o_credit, e_credit);
      end
    end
    idle();
    checks++;
    if (o_en !== 4'b1110 || o_en !== e_en) begin
      errors++;
      $display("FAIL drain_en: en=%b required=1110", o_en);
    end
  endtask

  task automatic test_simultaneous();
    idle(); ret[0] = 1'b1; step();
    idle(); send_on(0); ret[0] = 1'b1; step();
    checks++;
    if (o_credit[0] !== 3'd1 || o_en[0] !== 1'b1) begin
      errors++;
      $display("FAIL simul_at_1: credit=%0d en=%b required credit=1 en=1", o_credit[0], o_en[0]);
    end
    idle(); send_on(0); step();
    idle(); send_on(0); ret[0] = 1'b1; step();
    checks++;
    if (o_credit[0] !== 3'd0 || o_en[0] !== 1'b0 || o_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL simul_at_0: credit=%0d en=%b err=%b required credit=0 en=0 err=0",
               o_credit[0], o_en[0], o_err[0]);
    end
    for (int i = 0; i < 4; i++) begin
      idle(); ret[0] = 1'b1; step();
    end
    idle();
    checks++;
    if ({o_en, o_err, o_credit} !== {e_en, e_err, e_credit} || o_credit[0] !== 3'd4) begin
      errors++;
      $display("FAIL refill: en=%b err=%b credit=%h required en=%b err=%b credit=%h",
               o_en, o_err, o_credit, e_en, e_err, e_credit);
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 4; i++) begin
      idle(); send_on(1); step();
    end
    idle(); send_on(1); step();
    idle();
    checks++;
    if (o_err[1] !== 1'b1 || o_en[1] !== 1'b0 || o_err !== e_err) begin
      errors++;
      $display("FAIL underflow: err=%b en=%b required err[1]=1 en[1]=0", o_err, o_en);
    end
    for (int i = 0; i < 2; i++) begin
      idle(); ret[1] = 1'b1; step();
    end
    idle();
    checks++;
    if (o_credit[1] !== 3'd0 || o_en[1] !== 1'b0) begin
      errors++;
      $display("FAIL err_ignores_ret: credit=%0d en=%b required credit=0 en=0", o_credit[1], o_en[1]);
    end
    clr[1] = 1'b1; send_on(1); step();
    idle();
    checks++;
    if (o_credit[1] !== 3'd4 || o_en[1] !== 1'b1 || o_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: credit=%0d en=%b err=%b required credit=4 en=1 err=0",
               o_credit[1], o_en[1], o_err[1]);
    end
  endtask

  task automatic test_overflow();
    idle(); ret[3] = 1'b1; step();
    idle();
    checks++;
    if (o_err[3] !== 1'b1 || o_en[3] !== 1'b0 || o_credit[3] !== 3'd4) begin
      errors++;
      $display("FAIL overflow: err=%b en=%b credit=%0d required err=1 en=0 credit=4",
               o_err[3], o_en[3], o_credit[3]);
    end
    clr[3] = 1'b1; step();
    idle();
    checks++;
    if ({o_en, o_err, o_credit} !== {e_en, e_err, e_credit}) begin
      errors++;
      $display("FAIL overflow_clear: en=%b err=%b required en=%b err=%b", o_en, o_err, e_en, e_err);
    end
  endtask

  task automatic test_ce_hold();
    idle(); send_on(0); step();
    for (int i = 0; i < 5; i++) begin
      ce    = 1'b0;
      grant = M*N'($urandom);
      ret   = M'($urandom);
      clr   = M'($urandom);
      step();
      checks++;
      if ({o_en, o_err, o_wdog, o_credit} !== {e_en, e_err, e_wdog, e_credit} || o_credit[0] !== 3'd3) begin
        errors++;
        $display("FAIL ce_hold%0d: en=%b err=%b credit=%h required en=%b err=%b credit=%h",
                 i, o_en, o_err, o_credit, e_en, e_err, e_credit);
      end
    end
    idle(); ret[0] = 1'b1; step();
    idle();
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < 4; i++) begin
      idle(); send_on(2); step();
    end
    idle();
    for (int i = 0; i < WDOG_LIMIT - 1; i++) step();
    checks++;
    if (o_wdog[2] !== 1'b0) begin
      errors++;
      $display("FAIL wdog_early: wdog=%b required 0", o_wdog[2]);
    end
    step();
    checks++;
    if (o_wdog[2] !== WD_ON || o_wdog !== e_wdog) begin
      errors++;
      $display("FAIL wdog_fire: wdog=%b required %b", o_wdog, e_wdog);
    end
    ret[2] = 1'b1; step();
    idle();
    checks++;
    if (o_wdog[2] !== WD_ON || o_credit[2] !== 3'd1 || o_en[2] !== 1'b1) begin
      errors++;
      $display("FAIL wdog_sticky: wdog=%b credit=%0d en=%b required wdog=%b credit=1 en=1",
               o_wdog[2], o_credit[2], o_en[2], WD_ON);
    end
    clr[2] = 1'b1; step();
    idle();
    checks++;
    if (o_wdog[2] !== 1'b0 || o_credit[2] !== 3'd1) begin
      errors++;
      $display("FAIL wdog_clear: wdog=%b credit=%0d required wdog=0 credit=1", o_wdog[2], o_credit[2]);
    end
    for (int i = 0; i < 3; i++) begin
      ret[2] = 1'b1; step();
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ce = ($urandom_range(7, 0) != 0);
      for (int m = 0; m < M; m++) begin
        grant[m] = '0;
        if ($urandom_range(1, 0) != 0) grant[m][$urandom_range(N-1, 0)] = 1'b1;
        ret[m] = ($urandom_range(2, 0) == 0);
        clr[m] = ($urandom_range(9, 0) == 0);
      end
      step();
      checks++;
      if ({o_en, o_err, o_wdog, o_credit} !== {e_en, e_err, e_wdog, e_credit}) begin
        errors++;
        $display("FAIL random%0d: en=%b err=%b wdog=%b credit=%h required en=%b err=%b wdog=%b credit=%h",
                 i, o_en, o_err, o_wdog, o_credit, e_en, e_err, e_wdog, e_credit);
      end
    end
    idle();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_drain();
    test_simultaneous();
    test_underflow();
    test_overflow();
    test_ce_hold();
    test_watchdog();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
